// File: rtl/cpu_run_pkg.sv
// -----------------------------------------------------------------------------
// cpu_run_pkg
//   Shared definitions for the CPU run controller:
//   - run_state_e : 3-bit FSM state encoding (IDLE, RST_CPU, RUN, CHECK, DONE)
//   - DEF_*       : default parameter values used by the controller and watchdog
// -----------------------------------------------------------------------------
package cpu_run_pkg;

    localparam int unsigned DEF_DATA_W       = 64;
    localparam int unsigned DEF_CNT_W        = 16;
    localparam int unsigned DEF_RESET_CYCLES = 2;
    localparam int unsigned DEF_WDOG_LIMIT   = 255;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RST_CPU = 3'd1,
        RUN     = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4
    } run_state_e;

endpackage

// File: rtl/run_watchdog.sv
// -----------------------------------------------------------------------------
// run_watchdog
//   Saturating run-cycle counter with an expire flag.
// Ports:
//   i_clk     clock, posedge
//   i_clear   synchronous clear to zero (has priority over i_en)
//   i_en      count enable; the counter sticks at all-ones
//   o_count   current count (registered)
//   o_expire  high while o_count == LIMIT-1, i.e. the last permitted cycle
// -----------------------------------------------------------------------------
module run_watchdog
    import cpu_run_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned LIMIT = DEF_WDOG_LIMIT
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_expire = (r_count == LAST);

endmodule

// File: rtl/cpu_run_controller.sv
// -----------------------------------------------------------------------------
// cpu_run_controller
//   Run controller and result checker for the single-cycle CPU. Holds the CPU
//   in reset, releases it at start_pc, waits for currentpc >= end_pc, then
//   compares MemtoRegOut with the expected value. A watchdog bounds the run.
// Ports:
//   CLK, reset              clock and synchronous active-high reset
//   start                   run request, honoured only in IDLE or DONE
//   start_pc/end_pc/expected run parameters, latched on start acceptance
//   currentpc, MemtoRegOut  observed CPU state
//   cpu_resetl, startpc     CPU reset (active-low) and start PC
//   busy, done, pass, timeout, cycle_count   run status
// -----------------------------------------------------------------------------
module cpu_run_controller
    import cpu_run_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int unsigned WDOG_LIMIT   = DEF_WDOG_LIMIT
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] start_pc,
    input  logic [DATA_W-1:0] end_pc,
    input  logic [DATA_W-1:0] expected,
    input  logic [DATA_W-1:0] currentpc,
    input  logic [DATA_W-1:0] MemtoRegOut,
    output logic              cpu_resetl,
    output logic [DATA_W-1:0] startpc,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int unsigned      RST_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);

    run_state_e        r_state;
    logic [RST_W-1:0]  r_rst_cnt;
    logic [DATA_W-1:0] r_end_pc;
    logic [DATA_W-1:0] r_expected;
    logic [DATA_W-1:0] r_startpc;
    logic              r_cpu_resetl;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              r_timeout;

    logic              w_accept;
    logic              w_reached;
    logic              w_wd_clear;
    logic              w_wd_en;
    logic              w_wd_expire;
    logic [CNT_W-1:0]  w_count;

    assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_reached = (currentpc >= r_end_pc);

    // Count is cleared on acceptance so it reads 0 throughout RST_CPU, and
    // does not advance on the completing cycle so it records where PC landed.
    assign w_wd_clear = reset || w_accept;
    assign w_wd_en    = (r_state == RUN) && !w_reached;

    run_watchdog #(
        .CNT_W (CNT_W),
        .LIMIT (WDOG_LIMIT)
    ) u_watchdog (
        .i_clk    (CLK),
        .i_clear  (w_wd_clear),
        .i_en     (w_wd_en),
        .o_count  (w_count),
        .o_expire (w_wd_expire)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rst_cnt    <= '0;
            r_end_pc     <= '0;
            r_expected   <= '0;
            r_startpc    <= '0;
            r_cpu_resetl <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
        end else if (w_accept) begin
            r_state      <= RST_CPU;
            r_rst_cnt    <= '0;
            r_end_pc     <= end_pc;
            r_expected   <= expected;
            r_startpc    <= start_pc;
            r_cpu_resetl <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                RST_CPU: begin
                    if (r_rst_cnt == RST_LAST) begin
                        r_state      <= RUN;
                        r_cpu_resetl <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RST_W'(1);
                    end
                end
                RUN: begin
                    // Reaching end_pc wins over an expiring watchdog.
                    if (w_reached) begin
                        r_state <= CHECK;
                    end else if (w_wd_expire) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end
                CHECK: begin
                    r_state   <= DONE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_pass    <= (MemtoRegOut == r_expected);
                    r_timeout <= 1'b0;
                end
                default: begin
                    // IDLE and DONE hold until a start is accepted.
                end
            endcase
        end
    end

    assign cpu_resetl  = r_cpu_resetl;
    assign startpc     = r_startpc;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout     = r_timeout;
    assign cycle_count = w_count;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Two controllers share all stimulus: u0 with the default watchdog (255) and
// u1 with a watchdog of 8. Each drives its own behavioural CPU (PC <= startpc
// in reset, else PC+4). Expected outputs come from a run-level model: each
// accepted run is summarised by the number of PC steps needed to reach end_pc,
// and every output is a function of the cycles elapsed since acceptance.
module tb_cpu_run_controller;

    localparam int RC   = 2;
    localparam int LIM0 = 255;
    localparam int LIM1 = 8;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic [63:0] start_pc = '0;
    logic [63:0] end_pc   = '0;
    logic [63:0] expected = '0;
    logic [63:0] memout   = '0;

    logic [63:0] pc      [2];
    logic        resetl  [2];
    logic [63:0] spc_o   [2];
    logic        busy_o  [2];
    logic        done_o  [2];
    logic        pass_o  [2];
    logic        to_o    [2];
    logic [15:0] cnt_o   [2];

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    cpu_run_controller u0 (
        .CLK         (CLK),
        .reset       (reset),
        .start       (start),
        .start_pc    (start_pc),
        .end_pc      (end_pc),
        .expected    (expected),
        .currentpc   (pc[0]),
        .MemtoRegOut (memout),
        .cpu_resetl  (resetl[0]),
        .startpc     (spc_o[0]),
        .busy        (busy_o[0]),
        .done        (done_o[0]),
        .pass        (pass_o[0]),
        .timeout     (to_o[0]),
        .cycle_count (cnt_o[0])
    );

    cpu_run_controller #(
        .WDOG_LIMIT (LIM1)
    ) u1 (
        .CLK         (CLK),
        .reset       (reset),
        .start       (start),
        .start_pc    (start_pc),
        .end_pc      (end_pc),
        .expected    (expected),
        .currentpc   (pc[1]),
        .MemtoRegOut (memout),
        .cpu_resetl  (resetl[1]),
        .startpc     (spc_o[1]),
        .busy        (busy_o[1]),
        .done        (done_o[1]),
        .pass        (pass_o[1]),
        .timeout     (to_o[1]),
        .cycle_count (cnt_o[1])
    );

    // Behavioural CPUs.
    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            pc[i] <= resetl[i] ? pc[i] + 64'd4 : spc_o[i];
        end
    end

    // ---------------- run-level reference model ----------------
    bit          m_run   [2];
    int          m_e     [2];
    int          m_d     [2];
    longint      m_cap   [2];
    bit          m_to    [2];
    bit          m_match [2];
    logic [63:0] m_spc   [2];
    logic [63:0] m_exp   [2];

    function automatic int lim_of(input int i);
        return (i == 0) ? LIM0 : LIM1;
    endfunction

    function automatic bit m_busy(input int i);
        return m_run[i] && (m_e[i] < m_d[i]);
    endfunction

    always @(posedge CLK) begin
        longint unsigned diff;
        longint unsigned steps;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_run[i] = 1'b0;
                m_e[i]   = 0;
                m_spc[i] = '0;
            end else if (start && !m_busy(i)) begin
                m_run[i]   = 1'b1;
                m_e[i]     = 0;
                m_spc[i]   = start_pc;
                m_exp[i]   = expected;
                m_match[i] = 1'b0;
                diff  = (end_pc > start_pc) ? end_pc - start_pc : 64'd0;
                steps = (diff + 64'd3) >> 2;
                if (steps <= longint'(lim_of(i) - 1)) begin
                    m_to[i]  = 1'b0;
                    m_cap[i] = longint'(steps);
                    m_d[i]   = RC + int'(steps) + 2;
                end else begin
                    m_to[i]  = 1'b1;
                    m_cap[i] = longint'(lim_of(i));
                    m_d[i]   = RC + lim_of(i);
                end
            end else if (m_run[i]) begin
                // Edge leaving the compare cycle: result reflects MemtoRegOut now.
                if (!m_to[i] && (m_e[i] == m_d[i] - 1)) m_match[i] = (memout == m_exp[i]);
                if (m_e[i] < 1000000) m_e[i]++;
            end
        end
    end

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned req);
        n_total++;
        if (act != req) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                bit     e_busy, e_done, e_rl;
                longint e_cnt;
                e_busy = m_run[i] && (m_e[i] < m_d[i]);
                e_done = m_run[i] && (m_e[i] >= m_d[i]);
                e_rl   = m_run[i] && (m_e[i] >= RC);
                if (!m_run[i] || m_e[i] < RC) e_cnt = 0;
                else e_cnt = (longint'(m_e[i] - RC) < m_cap[i]) ? longint'(m_e[i] - RC) : m_cap[i];
                chk($sformatf("u%0d.busy", i), 64'(busy_o[i]), 64'(e_busy));
                chk($sformatf("u%0d.done", i), 64'(done_o[i]), 64'(e_done));
                chk($sformatf("u%0d.cpu_resetl", i), 64'(resetl[i]), 64'(e_rl));
                chk($sformatf("u%0d.cycle_count", i), 64'(cnt_o[i]), 64'(e_cnt));
                chk($sformatf("u%0d.pass", i), 64'(pass_o[i]), 64'(e_done && !m_to[i] && m_match[i]));
                chk($sformatf("u%0d.timeout", i), 64'(to_o[i]), 64'(e_done && m_to[i]));
                chk($sformatf("u%0d.startpc", i), spc_o[i], m_spc[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic launch(input logic [63:0] s, input logic [63:0] e, input logic [63:0] x,
                          input logic [63:0] m);
        start_pc = s;
        end_pc   = e;
        expected = x;
        memout   = m;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int idx);
        int n = 0;
        while (!done_o[idx] && n < 600) begin
            tick();
            n++;
        end
        n_total++;
        if (!done_o[idx]) begin
            n_bad++;
            $display("FAIL wait_done u%0d: done=0 after %0d cycles, required 1", idx, n);
        end
    endtask

    function automatic logic [63:0] pick(input int unsigned sel);
        case (sel)
            0:       return 64'h0;
            1:       return 64'h1;
            2:       return 64'h8000_0000_0000_0000;
            default: return 64'h8000_0000_0000_0001;
        endcase
    endfunction

    initial begin
        int n;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        // Reset state.
        chk("rst.cpu_resetl", 64'(resetl[0]), 0);
        chk("rst.busy", 64'(busy_o[0]), 0);
        chk("rst.cycle_count", 64'(cnt_o[0]), 0);
        chk("rst.startpc", spc_o[0], 0);
        reset = 1'b0;
        tick();

        // T1 pass.
        launch(64'h0, 64'h30, 64'hF, 64'hF);
        chk("t1.busy_after_accept", 64'(busy_o[0]), 1);
        wait_done(0);
        chk("t1.cycle_count", 64'(cnt_o[0]), 12);
        chk("t1.pass", 64'(pass_o[0]), 1);
        chk("t1.timeout", 64'(to_o[0]), 0);

        // T2 mismatch.
        launch(64'h0, 64'h30, 64'hF, 64'hE);
        wait_done(0);
        chk("t2.pass", 64'(pass_o[0]), 0);
        chk("t2.timeout", 64'(to_o[0]), 0);

        // T3 timeout.
        launch(64'h0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 64'h0);
        wait_done(0);
        chk("t3.timeout", 64'(to_o[0]), 1);
        chk("t3.pass", 64'(pass_o[0]), 0);
        chk("t3.cycle_count", 64'(cnt_o[0]), 255);

        // T4 reset mid-run.
        launch(64'h0, 64'h1000, 64'h0, 64'h0);
        n = 0;
        while (cnt_o[0] != 16'd5 && n < 50) begin
            tick();
            n++;
        end
        chk("t4.reached_count5", 64'(cnt_o[0]), 5);
        reset = 1'b1;
        tick();
        chk("t4.cpu_resetl", 64'(resetl[0]), 0);
        chk("t4.busy", 64'(busy_o[0]), 0);
        chk("t4.done", 64'(done_o[0]), 0);
        chk("t4.cycle_count", 64'(cnt_o[0]), 0);
        reset = 1'b0;
        tick();

        // T5 start ignored while busy, then back-to-back from DONE.
        launch(64'h0, 64'h100, 64'h1234_5678_9abc_def0, 64'h1234_5678_9abc_def0);
        tick();
        tick();
        start_pc = 64'h800;
        end_pc   = 64'h0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("t5.startpc_held", spc_o[0], 0);
        chk("t5.still_busy", 64'(busy_o[0]), 1);
        wait_done(0);
        chk("t5a.cycle_count", 64'(cnt_o[0]), 64);
        chk("t5a.pass", 64'(pass_o[0]), 1);
        launch(64'h0, 64'h54, 64'h1234_5678_9abc_def0, 64'h1234_5678_9abc_def0);
        wait_done(0);
        chk("t5b.cycle_count", 64'(cnt_o[0]), 21);
        chk("t5b.pass", 64'(pass_o[0]), 1);

        // T6 end_pc reached on the watchdog-limit cycle of u1.
        launch(64'h0, 64'h1C, 64'h55, 64'h55);
        wait_done(1);
        chk("t6.cycle_count", 64'(cnt_o[1]), 7);
        chk("t6.pass", 64'(pass_o[1]), 1);
        chk("t6.timeout", 64'(to_o[1]), 0);

        // end_pc below start_pc completes on the first RUN cycle.
        launch(64'h40, 64'h10, 64'h7, 64'h7);
        wait_done(0);
        chk("lo_end.cycle_count", 64'(cnt_o[0]), 0);
        chk("lo_end.pass", 64'(pass_o[0]), 1);

        // Randomized traffic.
        for (int c = 0; c < 5000; c++) begin
            reset    = ($urandom_range(0, 299) == 0);
            start    = ($urandom_range(0, 5) == 0);
            start_pc = 64'($urandom_range(0, 2000));
            if ($urandom_range(0, 4) == 0) end_pc = 64'($urandom_range(0, 2000));
            else end_pc = start_pc + 64'($urandom_range(0, 1200));
            expected = pick($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) memout = pick($urandom_range(0, 3));
            tick();
        end
        reset = 1'b0;
        start = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
